// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// the NOP instruction and the default widths.
package instr_fetch_pkg;

    localparam int PC_WIDTH_DEF        = 8;
    localparam int PROG_DATA_WIDTH_DEF = 16;
    localparam int LIT_WIDTH_DEF       = 8;

    localparam logic [15:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next program-counter selection: sequential step, absolute load or
// signed relative branch, all wrapping modulo 2^PC_WIDTH.
module pc_next_calc
    import instr_fetch_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int LitWidth = LIT_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [LitWidth-1:0] literal_adr,
    input  logic                cnt_wr_en,
    input  logic                add_offset,
    output logic [PC_WIDTH-1:0] next_pc
);

    logic [PC_WIDTH-1:0] lit_abs;
    logic [PC_WIDTH-1:0] lit_rel;

    // Absolute targets are zero-extended, relative offsets sign-extended.
    generate
        if (LitWidth >= PC_WIDTH) begin : g_trunc
            assign lit_abs = literal_adr[PC_WIDTH-1:0];
            assign lit_rel = literal_adr[PC_WIDTH-1:0];
        end else begin : g_ext
            assign lit_abs = {{(PC_WIDTH-LitWidth){1'b0}}, literal_adr};
            assign lit_rel = {{(PC_WIDTH-LitWidth){literal_adr[LitWidth-1]}}, literal_adr};
        end
    endgenerate

    always_comb begin
        next_pc = pc + PC_WIDTH'(1);
        if (cnt_wr_en) begin
            next_pc = add_offset ? (pc + lit_rel) : lit_abs;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one instruction at a time from program
// memory, presents it to the decoder for a single EXEC cycle, then advances pc.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_WIDTH          = PC_WIDTH_DEF,
    parameter int PROGRAM_DataWidth = PROG_DATA_WIDTH_DEF,
    parameter int LitWidth          = LIT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    output logic                         mem_req,
    output logic [PC_WIDTH-1:0]          mem_addr,
    input  logic                         mem_ack,
    input  logic [PROGRAM_DataWidth-1:0] mem_rdata,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic                         instr_valid,
    input  logic                         cnt_wr_en,
    input  logic                         add_offset,
    input  logic [LitWidth-1:0]          literal_adr,
    output logic [PC_WIDTH-1:0]          pc,
    output logic [15:0]                  instr_count
);

    state_t                       state_reg;
    logic [PC_WIDTH-1:0]          pc_reg;
    logic [PC_WIDTH-1:0]          pc_next;
    logic [PROGRAM_DataWidth-1:0] ir_reg;
    logic [15:0]                  count_reg;
    logic                         mem_req_reg;
    logic                         instr_valid_reg;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH),
        .LitWidth (LitWidth)
    ) u_pc_next_calc (
        .pc          (pc_reg),
        .literal_adr (literal_adr),
        .cnt_wr_en   (cnt_wr_en),
        .add_offset  (add_offset),
        .next_pc     (pc_next)
    );

    // A fetch, once started, always runs through EXEC; run only decides
    // whether another fetch follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= '0;
            ir_reg          <= '0;
            count_reg       <= '0;
            mem_req_reg     <= 1'b0;
            instr_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (run) begin
                        state_reg   <= FETCH;
                        mem_req_reg <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        ir_reg          <= mem_rdata;
                        state_reg       <= EXEC;
                        mem_req_reg     <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                EXEC: begin
                    pc_reg          <= pc_next;
                    count_reg       <= count_reg + 16'd1;
                    instr_valid_reg <= 1'b0;
                    state_reg       <= run ? FETCH : IDLE;
                    mem_req_reg     <= run;
                end
                default: begin
                    state_reg       <= IDLE;
                    mem_req_reg     <= 1'b0;
                    instr_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // The decoder sees NOP whenever nothing is executing.
    assign instruction = instr_valid_reg ? ir_reg : PROGRAM_DataWidth'(NOP);
    assign instr_valid = instr_valid_reg;
    assign mem_req     = mem_req_reg;
    assign mem_addr    = pc_reg;
    assign pc          = pc_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a simple
// instruction-level model of pc and retired-instruction count.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        cnt_wr_en = 1'b0;
    logic        add_offset = 1'b0;
    logic [7:0]  literal_adr = 8'h0;
    logic [7:0]  pc;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    int pc_m = 0;
    int count_m = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .cnt_wr_en   (cnt_wr_en),
        .add_offset  (add_offset),
        .literal_adr (literal_adr),
        .pc          (pc),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge while the DUT is fetching; executes one instruction
    // and leaves at the negedge after EXEC. Model updates pc/count afterwards.
    task automatic run_instr(input int delay, input logic wr, input logic add,
                             input logic [7:0] lit, input logic [15:0] data);
        int offs;
        for (int d = 0; d <= delay; d++) begin
            chk("fetch_req", mem_req, 1'b1);
            chk("fetch_addr", mem_addr, pc_m[7:0]);
            chk("fetch_valid", instr_valid, 1'b0);
            chk("fetch_nop", instruction, 16'h0000);
            mem_ack   = (d == delay);
            mem_rdata = (d == delay) ? data : 16'($urandom);
            @(negedge clk);
        end
        mem_ack = 1'($urandom);
        chk("exec_valid", instr_valid, 1'b1);
        chk("exec_instr", instruction, data);
        chk("exec_pc", pc, pc_m[7:0]);
        cnt_wr_en   = wr;
        add_offset  = add;
        literal_adr = lit;
        @(negedge clk);
        cnt_wr_en   = 1'b0;
        add_offset  = 1'b0;
        literal_adr = 8'($urandom);
        mem_ack     = 1'b0;
        offs = (lit >= 8'd128) ? int'(lit) - 256 : int'(lit);
        if (!wr)      pc_m = (pc_m + 1) % 256;
        else if (add) pc_m = (pc_m + offs + 256) % 256;
        else          pc_m = int'(lit);
        count_m = (count_m + 1) % 65536;
        chk("count", instr_count, count_m[15:0]);
        $display("instr done: data=%h wr=%0d add=%0d lit=%h -> pc=%h count=%0d",
                 data, wr, add, lit, pc_m[7:0], count_m);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_pc", pc, 8'h00);
        chk("rst_count", instr_count, 16'h0000);
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);

        // Sequential flow: addresses 0..4, count reaches 4 after 4 instructions
        for (int i = 0; i < 5; i++) begin
            run_instr(0, 1'b0, 1'b0, 8'h00, 16'($urandom));
            if (i == 3) chk("seq_count4", instr_count, 16'd4);
        end

        // Reset mid-FETCH at pc=5, then a stale ack after release
        chk("pre_rst_pc", pc, 8'h05);
        rst_n = 1'b0;
        #1;
        chk("async_req", mem_req, 1'b0);
        chk("async_pc", pc, 8'h00);
        chk("async_count", instr_count, 16'h0000);
        @(negedge clk);
        rst_n   = 1'b1;
        run     = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("stale_req", mem_req, 1'b0);
        chk("stale_valid", instr_valid, 1'b0);
        mem_ack = 1'b0;
        run     = 1'b1;
        pc_m    = 0;
        count_m = 0;
        @(negedge clk);

        // Absolute jump at pc=3 to 8'h40
        repeat (3) run_instr(0, 1'b0, 1'b0, 8'h00, 16'($urandom));
        run_instr(0, 1'b1, 1'b0, 8'h40, 16'hA5A5);
        chk("abs_addr", mem_addr, 8'h40);

        // Relative wrap, sequential wrap, zero offset
        run_instr(0, 1'b1, 1'b0, 8'h02, 16'h1234);
        run_instr(0, 1'b1, 1'b1, 8'hFE, 16'h2345);
        chk("rel_wrap", mem_addr, 8'h00);
        run_instr(0, 1'b1, 1'b0, 8'hFF, 16'h3456);
        run_instr(0, 1'b0, 1'b0, 8'h00, 16'h4567);
        chk("seq_wrap", mem_addr, 8'h00);
        run_instr(0, 1'b1, 1'b1, 8'h00, 16'h5678);
        chk("rel_zero", mem_addr, 8'h00);

        // Memory stall of 3 cycles
        run_instr(3, 1'b0, 1'b0, 8'h00, 16'hBEEF);

        // Stop during FETCH, then restart
        run = 1'b0;
        run_instr(1, 1'b0, 1'b0, 8'h00, 16'hCAFE);
        chk("stop_req", mem_req, 1'b0);
        @(negedge clk);
        chk("idle_req", mem_req, 1'b0);
        chk("idle_valid", instr_valid, 1'b0);
        run = 1'b1;
        @(negedge clk);
        run_instr(0, 1'b0, 1'b0, 8'h00, 16'h0F0F);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            run_instr(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                      8'($urandom), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
